// File: rtl/pipeline_stage_register_pkg.sv
// Shared CPU datapath definitions: hazard-control encoding and default stage payload widths.
package pipeline_stage_register_pkg;

   typedef enum logic [1:0] {
      CTRL_NONE  = 2'd0,
      CTRL_STALL = 2'd1,
      CTRL_FLUSH = 2'd2
   } ctrl_e;

   localparam int IF_ID_W  = 64;
   localparam int ID_EX_W  = 128;
   localparam int EX_MEM_W = 104;
   localparam int MEM_WB_W = 72;

   // Flush outranks stall when the hazard unit raises both.
   function automatic ctrl_e encode_ctrl(input logic stall, input logic flush);
      if (flush)
         return CTRL_FLUSH;
      else if (stall)
         return CTRL_STALL;
      else
         return CTRL_NONE;
   endfunction

endpackage

// File: rtl/pipeline_stage_register_if.sv
// Stage bus: upstream valid/ready, downstream valid/ready, hazard controls and stall counter.
interface pipeline_stage_register_if
   import pipeline_stage_register_pkg::*;
#(
   parameter int DATA_W = IF_ID_W,
   parameter int CNT_W  = 16
);
   // A beat moves on a rising edge where valid && ready; valid never waits on ready.
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_ready;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic              out_ready;
   logic              stall;
   logic              flush;
   logic [CNT_W-1:0]  stall_count;

   modport master (
      output in_valid, in_data, out_ready, stall, flush,
      input  in_ready, out_valid, out_data, stall_count
   );

   modport slave (
      input  in_valid, in_data, out_ready, stall, flush,
      output in_ready, out_valid, out_data, stall_count
   );

endinterface

// File: rtl/pipeline_stage_register_sat_counter.sv
// Saturating up-counter; sticks at all-ones until reset.
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         count <= '0;
      else if (en && (count != {CNT_W{1'b1}}))
         count <= count + CNT_W'(1);
   end

endmodule

// File: rtl/pipeline_stage_register.sv
// Pipeline stage register with stall/flush and a saturating stall counter.
// Define PIPELINE_STAGE_SKID_EN for a two-entry skid buffer with registered in_ready.
module pipeline_stage_register
   import pipeline_stage_register_pkg::*;
#(
   parameter int                DATA_W     = IF_ID_W,
   parameter logic [DATA_W-1:0] BUBBLE_VAL = '0,
   parameter int                CNT_W      = 16
) (
   input logic                     clk,
   input logic                     rst,
   pipeline_stage_register_if.slave bus
);

   ctrl_e             ctrl;
   logic              main_valid;
   logic [DATA_W-1:0] main_data;
   logic              skid_valid;
   logic [DATA_W-1:0] skid_data;
   logic              in_fire;
   logic              out_fire;
   logic              main_free;

   assign ctrl          = encode_ctrl(bus.stall, bus.flush);
   assign bus.out_valid = main_valid && (ctrl == CTRL_NONE);
   assign bus.out_data  = main_data;
   assign out_fire      = bus.out_valid && bus.out_ready;
   assign main_free     = !main_valid || out_fire;
   assign in_fire       = bus.in_valid && bus.in_ready && (ctrl == CTRL_NONE);

`ifdef PIPELINE_STAGE_SKID_EN
   // Ready depends only on the skid flop, breaking the out_ready -> in_ready path.
   assign bus.in_ready = (ctrl == CTRL_FLUSH) || ((ctrl == CTRL_NONE) && !skid_valid);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         skid_valid <= 1'b0;
         skid_data  <= BUBBLE_VAL;
      end else begin
         case (ctrl)
            CTRL_FLUSH: skid_valid <= 1'b0;
            CTRL_STALL: begin end
            default: begin
               if (main_free)
                  skid_valid <= 1'b0;
               else if (in_fire) begin
                  skid_valid <= 1'b1;
                  skid_data  <= bus.in_data;
               end
            end
         endcase
      end
   end
`else
   assign bus.in_ready = (ctrl == CTRL_FLUSH) ||
                         ((ctrl == CTRL_NONE) && (bus.out_ready || !main_valid));
   assign skid_valid   = 1'b0;
   assign skid_data    = BUBBLE_VAL;
`endif

   // A flush accepts and drops the incoming beat; a stall freezes everything.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_valid <= 1'b0;
         main_data  <= BUBBLE_VAL;
      end else begin
         case (ctrl)
            CTRL_FLUSH: begin
               main_valid <= 1'b0;
               main_data  <= BUBBLE_VAL;
            end
            CTRL_STALL: begin end
            default: begin
               if (main_free) begin
                  if (skid_valid) begin
                     main_valid <= 1'b1;
                     main_data  <= skid_data;
                  end else if (in_fire) begin
                     main_valid <= 1'b1;
                     main_data  <= bus.in_data;
                  end else begin
                     main_valid <= 1'b0;
                  end
               end
            end
         endcase
      end
   end

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .en    (bus.stall),
      .count (bus.stall_count)
   );

endmodule

// File: tb/tb_pipeline_stage_register.sv
// Bench for pipeline_stage_register: directed scenarios plus a randomized run against a queue model.
module tb_pipeline_stage_register;
   import pipeline_stage_register_pkg::*;

   localparam int          DATA_W = 64;
   localparam int          CNT_W  = 16;
   localparam logic [63:0] BUBBLE = 64'h0000_0013_0000_0013;
`ifdef PIPELINE_STAGE_SKID_EN
   localparam int DEPTH = 2;
`else
   localparam int DEPTH = 1;
`endif

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   logic [DATA_W-1:0] exp_q[$];
   logic [DATA_W-1:0] last_out;
   logic [CNT_W-1:0]  m_cnt;
   logic [3:0]        m_cnt4;

   pipeline_stage_register_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();
   pipeline_stage_register_if #(.DATA_W(DATA_W), .CNT_W(4))     bus4 ();

   assign bus4.in_valid  = bus.in_valid;
   assign bus4.in_data   = bus.in_data;
   assign bus4.out_ready = bus.out_ready;
   assign bus4.stall     = bus.stall;
   assign bus4.flush     = bus.flush;

   pipeline_stage_register #(.DATA_W(DATA_W), .BUBBLE_VAL(BUBBLE), .CNT_W(CNT_W)) dut (
      .clk (clk), .rst (rst), .bus (bus)
   );

   pipeline_stage_register #(.DATA_W(DATA_W), .BUBBLE_VAL(BUBBLE), .CNT_W(4)) dut4 (
      .clk (clk), .rst (rst), .bus (bus4)
   );

   always #5 clk = ~clk;

   task automatic idle();
     bus.in_valid  = 1'b0;
     bus.in_data   = '0;
     bus.out_ready = 1'b1;
     bus.stall     = 1'b0;
     bus.flush     = 1'b0;
   endtask

   task automatic tick();
     @(posedge clk);
     #1;
   endtask

   task automatic do_reset();
     rst = 1'b1;
     idle();
     tick();
     tick();
     rst = 1'b0;
     exp_q.delete();
     last_out = BUBBLE;
     m_cnt    = '0;
     m_cnt4   = '0;
   endtask

   task automatic test_reset();
     do_reset();
     @(negedge clk);
     checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", bus.out_valid); end
     checks++; if (bus.out_data !== BUBBLE) begin errors++; $display("FAIL rst_out_data: got %h expected %h", bus.out_data, BUBBLE); end
     checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b expected 1", bus.in_ready); end
     checks++; if (bus.stall_count !== 16'd0) begin errors++; $display("FAIL rst_stall_count: got %0d expected 0", bus.stall_count); end
     bus.in_valid = 1'b1; bus.in_data = 64'h55; bus.out_ready = 1'b0;
     tick();
     bus.in_valid = 1'b0;
     checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL pre_async_valid: got %b expected 1", bus.out_valid); end
     #2 rst = 1'b1;
     #1;
     checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL async_out_valid: got %b expected 0", bus.out_valid); end
     checks++; if (bus.out_data !== BUBBLE) begin errors++; $display("FAIL async_out_data: got %h expected %h", bus.out_data, BUBBLE); end
     checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL async_in_ready: got %b expected 1", bus.in_ready); end
     tick();
     rst = 1'b0;
     idle();
   endtask

   task automatic test_stream();
     do_reset();
     for (int i = 1; i <= 3; i++) begin
       bus.in_valid = 1'b1; bus.in_data = DATA_W'(i);
       tick();
       checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== DATA_W'(i)) begin
         errors++; $display("FAIL stream_%0d: got valid=%b data=%h expected valid=1 data=%h", i, bus.out_valid, bus.out_data, DATA_W'(i));
       end
     end
     bus.in_valid = 1'b0;
     tick();
     checks++; if (bus.out_valid !== 1'b0 || bus.out_data !== 64'h3) begin
       errors++; $display("FAIL stream_drain: got valid=%b data=%h expected valid=0 data=3", bus.out_valid, bus.out_data);
     end
   endtask

   task automatic test_stall();
     do_reset();
     bus.in_valid = 1'b1; bus.in_data = 64'hA; bus.out_ready = 1'b0;
     tick();
     bus.in_valid = 1'b0; bus.stall = 1'b1; bus.out_ready = 1'b1;
     for (int i = 0; i < 3; i++) begin
       @(negedge clk);
       checks++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_data !== 64'hA) begin
         errors++; $display("FAIL stall_hold_%0d: got ready=%b valid=%b data=%h expected ready=0 valid=0 data=a", i, bus.in_ready, bus.out_valid, bus.out_data);
       end
       tick();
     end
     bus.stall = 1'b0;
     @(negedge clk);
     checks++; if (bus.stall_count !== 16'd3) begin errors++; $display("FAIL stall_count3: got %0d expected 3", bus.stall_count); end
     checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 64'hA) begin
       errors++; $display("FAIL stall_release: got valid=%b data=%h expected valid=1 data=a", bus.out_valid, bus.out_data);
     end
     tick();
     checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL stall_delivered_once: got valid=%b expected 0", bus.out_valid); end
   endtask

   task automatic test_flush();
     do_reset();
     bus.in_valid = 1'b1; bus.in_data = 64'hB; bus.out_ready = 1'b0;
     tick();
     bus.flush = 1'b1; bus.stall = 1'b1; bus.in_data = 64'hC;
     @(negedge clk);
     checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready: got %b expected 1", bus.in_ready); end
     tick();
     bus.flush = 1'b0; bus.stall = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
     for (int i = 0; i < 3; i++) begin
       @(negedge clk);
       checks++; if (bus.out_valid !== 1'b0 || bus.out_data !== BUBBLE) begin
         errors++; $display("FAIL flush_bubble_%0d: got valid=%b data=%h expected valid=0 data=%h", i, bus.out_valid, bus.out_data, BUBBLE);
       end
       tick();
     end
   endtask

   task automatic test_backpressure();
     do_reset();
     bus.out_ready = 1'b0;
     bus.in_valid = 1'b1; bus.in_data = 64'hD;
     tick();
     bus.in_data = 64'hE;
     @(negedge clk);
     checks++; if (bus.in_ready !== (DEPTH == 2)) begin errors++; $display("FAIL bp_second_ready: got %b expected %b", bus.in_ready, DEPTH == 2); end
     tick();
     if (DEPTH == 2) bus.in_valid = 1'b0;
     @(negedge clk);
     checks++; if (bus.in_ready !== 1'b0 || bus.out_data !== 64'hD) begin
       errors++; $display("FAIL bp_full: got ready=%b data=%h expected ready=0 data=d", bus.in_ready, bus.out_data);
     end
     bus.out_ready = 1'b1;
     tick();
     bus.in_valid = 1'b0;
     checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 64'hE) begin
       errors++; $display("FAIL bp_second_out: got valid=%b data=%h expected valid=1 data=e", bus.out_valid, bus.out_data);
     end
     tick();
     checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
       errors++; $display("FAIL bp_empty: got valid=%b ready=%b expected valid=0 ready=1", bus.out_valid, bus.in_ready);
     end
   endtask

   task automatic test_saturation();
     do_reset();
     bus.stall = 1'b1;
     for (int i = 0; i < 20; i++) tick();
     bus.stall = 1'b0;
     @(negedge clk);
     checks++; if (bus4.stall_count !== 4'd15) begin errors++; $display("FAIL sat4: got %0d expected 15", bus4.stall_count); end
     checks++; if (bus.stall_count !== 16'd20) begin errors++; $display("FAIL cnt16: got %0d expected 20", bus.stall_count); end
     bus.flush = 1'b1;
     tick();
     bus.flush = 1'b0;
     checks++; if (bus.stall_count !== 16'd20 || bus4.stall_count !== 4'd15) begin
       errors++; $display("FAIL cnt_after_flush: got %0d/%0d expected 20/15", bus.stall_count, bus4.stall_count);
     end
   endtask

   task automatic test_random();
     logic              ov_e, ir_e;
     logic [DATA_W-1:0] od_e;
     do_reset();
     for (int c = 0; c < 500; c++) begin
       bus.in_valid  = ($urandom_range(0, 3) != 0);
       bus.in_data   = {$urandom, $urandom};
       bus.out_ready = ($urandom_range(0, 3) != 0);
       bus.stall     = ($urandom_range(0, 9) == 0);
       bus.flush     = ($urandom_range(0, 24) == 0);
       @(negedge clk);
       ov_e = !bus.stall && !bus.flush && (exp_q.size() > 0);
       od_e = (exp_q.size() > 0) ? exp_q[0] : last_out;
       if (bus.flush) ir_e = 1'b1;
       else if (bus.stall) ir_e = 1'b0;
       else if (DEPTH == 2) ir_e = (exp_q.size() < 2);
       else ir_e = (exp_q.size() == 0) || bus.out_ready;
       checks++; if (bus.out_valid !== ov_e) begin errors++; $display("FAIL rand_valid c%0d: got %b expected %b", c, bus.out_valid, ov_e); end
       checks++; if (bus.out_data !== od_e) begin errors++; $display("FAIL rand_data c%0d: got %h expected %h", c, bus.out_data, od_e); end
       checks++; if (bus.in_ready !== ir_e) begin errors++; $display("FAIL rand_ready c%0d: got %b expected %b", c, bus.in_ready, ir_e); end
       checks++; if (bus.stall_count !== m_cnt) begin errors++; $display("FAIL rand_cnt c%0d: got %0d expected %0d", c, bus.stall_count, m_cnt); end
       checks++; if (bus4.stall_count !== m_cnt4) begin errors++; $display("FAIL rand_cnt4 c%0d: got %0d expected %0d", c, bus4.stall_count, m_cnt4); end
       @(posedge clk);
       if (bus.stall) begin
         if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
         if (m_cnt4 != 4'hF) m_cnt4 = m_cnt4 + 4'd1;
       end
       if (bus.flush) begin
         exp_q.delete();
         last_out = BUBBLE;
       end else if (!bus.stall) begin
         if (ov_e && bus.out_ready) last_out = exp_q.pop_front();
         if (bus.in_valid && ir_e) exp_q.push_back(bus.in_data);
       end
       #1;
     end
     idle();
   endtask

   initial begin
     rst = 1'b1;
     idle();
     test_reset();
     test_stream();
     test_stall();
     test_flush();
     test_backpressure();
     test_saturation();
     test_random();
     $display("Simulation finished: %0d checks, %0d errors", checks, errors);
     $finish;
   end

endmodule
